// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - R-type Funct codes for the HI/LO instruction group
//   - FSM state encoding
//   - operation descriptor (multiply or divide, plus signedness)
package md_pkg;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_kind_t;

    typedef struct packed {
        op_kind_t kind;
        logic     sgn;
    } op_t;

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one-bit-per-cycle shift-add multiplier / restoring divider
// working on unsigned operand magnitudes.
//   clk, reset : clock, async active-high reset
//   load       : capture a_mag/b_mag and clear the iteration counter
//   step       : perform one iteration
//   mode       : OP_MUL or OP_DIV
//   a_mag      : multiplier / dividend magnitude
//   b_mag      : multiplicand / divisor magnitude
//   last       : current step is the final (WIDTH-th) one
//   acc        : multiply -> {product_hi, product_lo}
//                divide   -> {remainder, quotient}
module md_iter_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  op_kind_t           mode,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic               last,
    output logic [2*WIDTH-1:0] acc
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_next;

    // Both algorithms share one 2*WIDTH register. Multiply adds the
    // multiplicand into the upper half when the multiplier LSB is set and
    // shifts right with carry. Divide shifts {rem, quo} left and keeps the
    // trial subtraction when it does not go negative.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        acc_next  = acc;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd};
        if (mode == OP_MUL) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_trial >= {1'b0, opnd}) begin
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

    // NOTE: datapath registers are reset as well, so hi/lo fix-up logic never
    // sees X even before the first operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, a_mag};
            opnd <= b_mag;
            cnt  <= '0;
        end else if (step) begin
            acc  <= acc_next;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit owning the HI/LO registers.
//   clk, reset  : clock, async active-high reset
//   start       : request strobe, only honoured in IDLE
//   Funct       : R-type funct (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   a, b        : rs / rt operands, captured on the accepted start edge
//   busy        : registered, high while iterating or fixing up signs
//   done        : one-cycle pulse, hi/lo valid
//   div_by_zero : qualifies done for a divide with b == 0
//   hi, lo      : HI/LO architectural registers
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state, state_next;
    op_t                op;
    logic               a_neg, b_neg;

    logic               is_mul, is_div, is_sgn, is_mthi, is_mtlo;
    logic               accept, b_zero, load, step, last;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Decode
    assign is_mul  = (Funct == FN_MULT) || (Funct == FN_MULTU);
    assign is_div  = (Funct == FN_DIV)  || (Funct == FN_DIVU);
    assign is_sgn  = (Funct == FN_MULT) || (Funct == FN_DIV);
    assign is_mthi = (Funct == FN_MTHI);
    assign is_mtlo = (Funct == FN_MTLO);
    assign accept  = start && (state == S_IDLE);
    assign b_zero  = (b == '0);

    // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1).
    assign a_mag = (is_sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_sgn && b[WIDTH-1]) ? -b : b;

    assign load = accept && (is_mul || (is_div && !b_zero));

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .mode  (op.kind),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .last  (last),
        .acc   (acc)
    );

    // Sign fix-up. Quotient truncates toward zero; remainder follows the
    // dividend. MIN / -1 wraps back to MIN with no special handling.
    assign prod_fix = (op.sgn && (a_neg ^ b_neg)) ? -acc : acc;
    assign quo_fix  = (op.sgn && (a_neg ^ b_neg)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = (op.sgn && a_neg) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        step       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_mul)      state_next = S_ITER;
                else if (accept && is_div) state_next = b_zero ? S_DONE : S_ITER;
            end
            S_ITER: begin
                step = 1'b1;
                if (last) state_next = S_FIX;
            end
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            op          <= '{kind: OP_MUL, sgn: 1'b0};
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
        end else begin
            // Registered status derived from where the FSM is heading.
            busy <= (state_next == S_ITER) || (state_next == S_FIX);
            done <= (state_next == S_DONE);

            if (accept) begin
                if (is_mthi) hi <= a;
                if (is_mtlo) lo <= a;
                if (is_mul || is_div) begin
                    op    <= '{kind: (is_div ? OP_DIV : OP_MUL), sgn: is_sgn};
                    a_neg <= a[WIDTH-1];
                    b_neg <= b[WIDTH-1];
                end
                if (is_mul || is_div || is_mthi || is_mtlo)
                    div_by_zero <= is_div && b_zero;
            end

            if (state == S_FIX) begin
                if (op.kind == OP_MUL) begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end else begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end
            end
        end
    end

endmodule
